// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared sizing constants and small types for the rename register file allocator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rrf_alloc_ctrl_pkg;

    localparam int RRF_ENT_NUM   = 64;
    localparam int RRF_ENT_SEL   = $clog2(RRF_ENT_NUM);
    localparam int RRF_OCC_WIDTH = RRF_ENT_SEL + 1;

    typedef logic [RRF_ENT_SEL-1:0]   rrf_tag_t;
    typedef logic [RRF_OCC_WIDTH-1:0] rrf_occ_t;
    typedef logic [1:0]               rrf_cnt_t;

    // Sum of two single-bit requests as a 0..2 count.
    function automatic rrf_cnt_t rrf_add2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/rrf_alloc_ctrl_ptr_adv.sv
// Modulo-RRF_ENT_NUM pointer adder: nxt = ptr + inc (inc in 0..2).
// Latency: purely combinational.
// Backpressure: none; wrap relies on RRF_ENT_NUM being a power of two.
module rrf_ptr_adv
    import rrf_alloc_ctrl_pkg::*;
(
    input  rrf_tag_t ptr,
    input  rrf_cnt_t inc,
    output rrf_tag_t nxt
);

    // Natural truncation of the tag width performs the modulo wrap.
    assign nxt = ptr + rrf_tag_t'(inc);

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// RRF allocation/release controller: in-order circular buffer, 2 allocs + 2 commits per cycle, flush rewind.
// Latency: tags, stall and commit pointers combinational; pointer/occupancy updates visible after one clk edge.
// Backpressure: o_dp_stall when requests exceed free entries or during flush; allocation is all-or-nothing.
module rrf_alloc_ctrl
    import rrf_alloc_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_dp_req_1,
    input  logic                   i_dp_req_2,
    output logic [RRF_ENT_SEL-1:0] o_dp_rrftag_1,
    output logic [RRF_ENT_SEL-1:0] o_dp_rrftag_2,
    output logic                   o_dp_stall,
    input  logic                   i_com_vld_1,
    input  logic                   i_com_vld_2,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr_1,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr_2,
    input  logic                   i_flush,
    input  logic [RRF_ENT_SEL-1:0] i_flush_rrfptr,
    output logic [RRF_ENT_SEL:0]   o_freenum,
    output logic                   o_rrf_empty
);

    rrf_tag_t alloc_ptr;
    rrf_tag_t com_ptr;
    rrf_occ_t occ;

    rrf_tag_t alloc_ptr_nxt;
    rrf_tag_t com_ptr_nxt;
    rrf_occ_t occ_nxt;

    rrf_cnt_t req_cnt;
    rrf_cnt_t alloc_cnt;
    rrf_cnt_t com_cnt;
    rrf_occ_t freenum;
    rrf_tag_t alloc_ptr_adv;
    rrf_tag_t flush_dist;

    assign req_cnt = rrf_add2(i_dp_req_1, i_dp_req_2);
    // Second commit only counts when the oldest entry also commits.
    assign com_cnt = rrf_add2(i_com_vld_1, i_com_vld_1 & i_com_vld_2);
    assign freenum = rrf_occ_t'(RRF_ENT_NUM) - occ;

    assign o_dp_stall  = (rrf_occ_t'(req_cnt) > freenum) | i_flush;
    assign alloc_cnt   = o_dp_stall ? 2'd0 : req_cnt;
    assign o_freenum   = freenum;
    assign o_rrf_empty = (occ == '0);

    assign o_dp_rrftag_1 = alloc_ptr;
    assign o_com_ptr_1   = com_ptr;

    // Slot 2 skips past slot 1's entry only when slot 1 actually requests.
    rrf_ptr_adv u_tag2_adv (
        .ptr (alloc_ptr),
        .inc ({1'b0, i_dp_req_1}),
        .nxt (o_dp_rrftag_2)
    );

    rrf_ptr_adv u_com2_adv (
        .ptr (com_ptr),
        .inc (2'd1),
        .nxt (o_com_ptr_2)
    );

    rrf_ptr_adv u_alloc_adv (
        .ptr (alloc_ptr),
        .inc (alloc_cnt),
        .nxt (alloc_ptr_adv)
    );

    rrf_ptr_adv u_com_adv (
        .ptr (com_ptr),
        .inc (com_cnt),
        .nxt (com_ptr_nxt)
    );

    // Entries surviving a flush: from the post-commit head up to the discard point.
    assign flush_dist = i_flush_rrfptr - com_ptr_nxt;

    // Next allocation pointer and occupancy; flush rewinds, otherwise net alloc minus commit.
    always_comb begin
        alloc_ptr_nxt = alloc_ptr_adv;
        occ_nxt       = occ + rrf_occ_t'(alloc_cnt) - rrf_occ_t'(com_cnt);
        if (i_flush) begin
            alloc_ptr_nxt = i_flush_rrfptr;
            occ_nxt       = {1'b0, flush_dist};
        end
    end

    // Pointer and occupancy state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= '0;
            com_ptr   <= '0;
            occ       <= '0;
        end else begin
            alloc_ptr <= alloc_ptr_nxt;
            com_ptr   <= com_ptr_nxt;
            occ       <= occ_nxt;
        end
    end

`ifndef SYNTHESIS
    a_com_order : assert property (@(posedge clk) disable iff (rst)
        i_com_vld_2 |-> i_com_vld_1);
    a_com_occ   : assert property (@(posedge clk) disable iff (rst)
        rrf_occ_t'(com_cnt) <= occ);
    a_flush_win : assert property (@(posedge clk) disable iff (rst)
        i_flush |-> (rrf_occ_t'(flush_dist) <= occ - rrf_occ_t'(com_cnt)));
`endif

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
module tb_rrf_alloc_ctrl;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_dp_req_1 = 1'b0;
    logic       i_dp_req_2 = 1'b0;
    logic [5:0] o_dp_rrftag_1;
    logic [5:0] o_dp_rrftag_2;
    logic       o_dp_stall;
    logic       i_com_vld_1 = 1'b0;
    logic       i_com_vld_2 = 1'b0;
    logic [5:0] o_com_ptr_1;
    logic [5:0] o_com_ptr_2;
    logic       i_flush = 1'b0;
    logic [5:0] i_flush_rrfptr = '0;
    logic [6:0] o_freenum;
    logic       o_rrf_empty;

    rrf_alloc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_dp_req_1     (i_dp_req_1),
        .i_dp_req_2     (i_dp_req_2),
        .o_dp_rrftag_1  (o_dp_rrftag_1),
        .o_dp_rrftag_2  (o_dp_rrftag_2),
        .o_dp_stall     (o_dp_stall),
        .i_com_vld_1    (i_com_vld_1),
        .i_com_vld_2    (i_com_vld_2),
        .o_com_ptr_1    (o_com_ptr_1),
        .o_com_ptr_2    (o_com_ptr_2),
        .i_flush        (i_flush),
        .i_flush_rrfptr (i_flush_rrfptr),
        .o_freenum      (o_freenum),
        .o_rrf_empty    (o_rrf_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stall;
        bit chk_t1;
        bit chk_t2;
        int t1;
        int t2;
        int c1;
        int c2;
        int free;
        int empty;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: oldest entry index plus the ordered list of live tags.
    int head = 0;
    int live[$];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are always presented, so every falling edge consumes one expectation.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("stall", o_dp_stall, e.stall);
            chk("com_ptr_1", o_com_ptr_1, e.c1);
            chk("com_ptr_2", o_com_ptr_2, e.c2);
            chk("freenum", o_freenum, e.free);
            chk("empty", o_rrf_empty, e.empty);
            if (e.chk_t1) chk("tag_1", o_dp_rrftag_1, e.t1);
            if (e.chk_t2) chk("tag_2", o_dp_rrftag_2, e.t2);
        end
    end

    task automatic cycle(input bit r, input bit r1, input bit r2, input bit v1,
                         input bit v2, input bit f, input int fp);
        exp_t e;
        int   rc, cc, ap, d;
        bit   st;
        @(posedge clk);
        #1;
        rst            = r;
        i_dp_req_1     = r1;
        i_dp_req_2     = r2;
        i_com_vld_1    = v1;
        i_com_vld_2    = v2;
        i_flush        = f;
        i_flush_rrfptr = 6'(fp);
        if (r) begin
            head = 0;
            live.delete();
        end
        rc = int'(r1) + int'(r2);
        cc = int'(v1) + int'(v1 && v2);
        ap = (head + live.size()) % N;
        st = (rc > N - live.size()) || f;
        e.stall  = int'(st);
        e.chk_t1 = !st && r1;
        e.chk_t2 = !st && r2;
        e.t1     = ap;
        e.t2     = (ap + int'(r1)) % N;
        e.c1     = head;
        e.c2     = (head + 1) % N;
        e.free   = N - live.size();
        e.empty  = int'(live.size() == 0);
        expq.push_back(e);
        if (!r) begin
            repeat (cc) void'(live.pop_front());
            head = (head + cc) % N;
            if (f) begin
                d = (fp - head + N) % N;
                while (live.size() > d) void'(live.pop_back());
            end else if (!st) begin
                if (r1) live.push_back(ap);
                if (r2) live.push_back((ap + int'(r1)) % N);
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int sz, cc, bias, wait_cnt;
        bit r1, r2, v1, v2, f;

        // Reset, then a single allocation from slot 1.
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        idle();

        // Fill to one free entry, then the two-request / one-request boundary, then full.
        cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (31) cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0);

        // Drain to com_ptr=62 with two live, then commit+alloc straddling the wrap.
        repeat (31) cycle(0, 0, 0, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 1, 0, 0);
        idle();

        // Flush with a concurrent commit and a (stalled) request.
        cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (15) cycle(0, 1, 1, 0, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 1, 1, 0, 0);
        cycle(0, 1, 0, 1, 0, 1, 15);
        idle();

        // Asynchronous reset mid-traffic at occupancy 40, sampled before any further edge.
        cycle(1, 0, 0, 0, 0, 0, 0);
        repeat (20) cycle(0, 1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle();

        // Randomized legal traffic with phases biased toward filling or draining.
        bias = 80;
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) bias = $urandom_range(10, 90);
            sz = live.size();
            r1 = ($urandom_range(0, 99) < bias);
            r2 = ($urandom_range(0, 99) < bias);
            v1 = (sz >= 1) && ($urandom_range(0, 99) >= bias);
            v2 = v1 && (sz >= 2) && ($urandom_range(0, 1) == 1);
            cc = int'(v1) + int'(v1 && v2);
            f  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 799) == 0)
                cycle(1, 0, 0, 0, 0, 0, 0);
            else
                cycle(0, r1, r2, v1, v2, f,
                      f ? (head + cc + int'($urandom_range(0, sz - cc))) % N : 0);
        end
        idle();

        wait_cnt = 0;
        while (expq.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rrf_alloc_ctrl.md
Name: rrf_alloc_ctrl

Overview:
- Allocation/release controller for the rename register file (RRF); manages entries as an in-order circular buffer.
- At dispatch, hands up to two RRF tags per cycle to renamed instructions.
- At commit, retires up to two tags per cycle and drives the RRF commit read pointers.
- On branch mispredict, rewinds the allocation pointer to the flush point.

Parameters:
- RRF_ENT_NUM, 64, number of RRF entries; must be a power of 2, ≥4.
- RRF_ENT_SEL, 6, tag width; equals log2(RRF_ENT_NUM).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- i_dp_req_1  in  1  dispatch slot 1 needs an RRF entry.
- i_dp_req_2  in  1  dispatch slot 2 needs an RRF entry.
- o_dp_rrftag_1  out  RRF_ENT_SEL  tag for slot 1.
- o_dp_rrftag_2  out  RRF_ENT_SEL  tag for slot 2.
- o_dp_stall  out  1  insufficient free entries; no allocation this cycle.
- i_com_vld_1  in  1  commit oldest entry.
- i_com_vld_2  in  1  commit second-oldest entry; only legal with i_com_vld_1.
- o_com_ptr_1  out  RRF_ENT_SEL  oldest tag, to the RRF commit read/clear port 1.
- o_com_ptr_2  out  RRF_ENT_SEL  oldest+1 tag, to RRF port 2.
- i_flush  in  1  mispredict recovery.
- i_flush_rrfptr  in  RRF_ENT_SEL  first tag to discard; becomes the new allocation pointer.
- o_freenum  out  RRF_ENT_SEL+1  free entry count.
- o_rrf_empty  out  1  occupancy == 0.

Behaviour:
- State:
  - alloc_ptr (RRF_ENT_SEL)
  - com_ptr (RRF_ENT_SEL)
  - occ (RRF_ENT_SEL+1, 0..RRF_ENT_NUM)
- Outputs: o_freenum = RRF_ENT_NUM − occ.
- Reset (async, rst=1): alloc_ptr=0, com_ptr=0, occ=0.
  - Hence o_freenum=RRF_ENT_NUM, o_rrf_empty=1, o_dp_stall=0, o_com_ptr_1=0, o_com_ptr_2=1.
  - Reset mid-operation discards all state immediately, with no clock needed.
- Request count: req_cnt = i_dp_req_1 + i_dp_req_2 (0..2).
- Stall (combinational): o_dp_stall = (req_cnt > o_freenum) | i_flush.
  - Allocation is all-or-nothing; there are no partial grants.
- Tags (combinational, valid when not stalled):
  - o_dp_rrftag_1 = alloc_ptr.
  - o_dp_rrftag_2 = alloc_ptr + i_dp_req_1, mod RRF_ENT_NUM.
  - Slot 2 alone therefore gets alloc_ptr.
- Allocation: alloc_cnt = o_dp_stall ? 0 : req_cnt. Next alloc_ptr = alloc_ptr + alloc_cnt, wrapping mod RRF_ENT_NUM.
- Commit:
  - com_cnt = i_com_vld_1 + (i_com_vld_1 & i_com_vld_2).
  - o_com_ptr_1 = com_ptr; o_com_ptr_2 = com_ptr + 1 (wrap).
  - Next com_ptr = com_ptr + com_cnt.
- Normal update: occ_next = occ + alloc_cnt − com_cnt. Simultaneous alloc and commit in one cycle is legal.
- Flush cycle:
  - Commit is still honoured; alloc_cnt = 0.
  - alloc_ptr_next = i_flush_rrfptr.
  - occ_next = (i_flush_rrfptr − com_ptr_next) mod RRF_ENT_NUM, zero-extended.
  - i_flush_rrfptr == com_ptr_next yields occ=0; a full buffer is never the flush result.
  - Takes effect the next cycle.
- Full: occ==RRF_ENT_NUM → o_freenum=0; any request stalls.
  - One free entry with two requests → stall; one request → grant.
- Wrap-around: alloc_ptr and com_ptr wrap modulo RRF_ENT_NUM; two tags may straddle entry N−1 → 0.
- Illegal inputs (simulation assertions only; no RTL recovery):
  - com_cnt > occ
  - i_com_vld_2 without i_com_vld_1
  - i_flush_rrfptr outside the occupied window [com_ptr_next, alloc_ptr]
- Latency:
  - Tags, stall and com_ptr are same-cycle combinational.
  - Pointer and occupancy updates are visible after one clk edge.

Decomposition:
- Shared constants header: RRF_ENT_NUM, RRF_ENT_SEL (existing), plus RRF_OCC_WIDTH = RRF_ENT_SEL+1.
- One natural sub-module: rrf_ptr_adv, a modulo-N pointer adder (ptr + 0/1/2). Instantiate it for alloc_ptr, com_ptr and the tag-2 computation.
- Everything else stays flat in rrf_alloc_ctrl.

Test Plan:
- Reset then single alloc: assert rst, release; req_1=1 for 1 cycle → o_dp_rrftag_1=0, stall=0; next cycle o_freenum=63, alloc_ptr=1.
- Dual alloc to full: 32 cycles of req_1=req_2=1 → tags 0/1, 2/3, …, 62/63; then o_freenum=0. Further request → o_dp_stall=1, pointers unchanged.
- Partial-space stall: occ=63 (freenum=1).
  - req_1=req_2=1 → stall=1, no change.
  - req_1 only → tag 63, o_freenum=0 next cycle.
- Simultaneous alloc/commit with wrap:
  - Setup: com_ptr=62, alloc_ptr=0, occ=2.
  - Stimulus: com_vld_1=com_vld_2=1, req_1=req_2=1.
  - Expected same cycle: o_com_ptr_1=62, o_com_ptr_2=63, tags 0/1.
  - Expected next cycle: com_ptr=0, alloc_ptr=2, occ=2.
- Flush with concurrent commit:
  - Setup: com_ptr=10, alloc_ptr=30, occ=20.
  - Stimulus: i_flush=1, i_flush_rrfptr=15, com_vld_1=1, req_1=1.
  - Expected: stall=1; next cycle alloc_ptr=15, com_ptr=11, occ=4, freenum=60.
- Async reset mid-traffic: assert rst between clk edges while occ=40 → outputs immediately return to reset values (freenum=64, empty=1) without a clock edge.
